dcache_port_arbiter: RTL and testbench

- Single-ported arbiter between the MEM-stage load path and the store-buffer drain path in front of the data cache.
- Grants one requester at a time and allows one outstanding cache transaction.
- Steers the cache response back to the owner.
- Loads have priority; a starvation counter and a store-buffer-full override guarantee forward progress for stores.

---
 rtl/dcache_port_arbiter_if.sv | 46 ++++
 rtl/dcache_port_arbiter.sv | 116 +++++++++++
 tb/tb_dcache_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the load, store-drain, cache and perf signals of the
// data-cache port arbiter. The arbiter uses the slave modport; the
// surrounding pipeline/cache side uses master.
interface dcache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              ld_req_valid_i;
  logic              ld_req_ready_o;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_rsp_valid_o;
  logic [DATA_W-1:0] ld_rsp_data_o;
  logic              st_req_valid_i;
  logic              st_req_ready_o;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic              st_rsp_valid_o;
  logic              sb_full_i;
  logic              dc_req_valid_o;
  logic              dc_req_ready_i;
  logic              dc_we_o;
  logic [ADDR_W-1:0] dc_addr_o;
  logic [DATA_W-1:0] dc_data_o;
  logic              dc_rsp_valid_i;
  logic [DATA_W-1:0] dc_rsp_data_i;
  logic              busy_o;
  logic [31:0]       perf_ld_grants_o;
  logic [31:0]       perf_st_grants_o;
  logic [31:0]       perf_conflict_o;

  modport slave (
    input  ld_req_valid_i, ld_addr_i, st_req_valid_i, st_addr_i, st_data_i,
           sb_full_i, dc_req_ready_i, dc_rsp_valid_i, dc_rsp_data_i,
    output ld_req_ready_o, ld_rsp_valid_o, ld_rsp_data_o, st_req_ready_o,
           st_rsp_valid_o, dc_req_valid_o, dc_we_o, dc_addr_o, dc_data_o,
           busy_o, perf_ld_grants_o, perf_st_grants_o, perf_conflict_o
  );

  modport master (
    output ld_req_valid_i, ld_addr_i, st_req_valid_i, st_addr_i, st_data_i,
           sb_full_i, dc_req_ready_i, dc_rsp_valid_i, dc_rsp_data_i,
    input  ld_req_ready_o, ld_rsp_valid_o, ld_rsp_data_o, st_req_ready_o,
           st_rsp_valid_o, dc_req_valid_o, dc_we_o, dc_addr_o, dc_data_o,
           busy_o, perf_ld_grants_o, perf_st_grants_o, perf_conflict_o
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Single-port data-cache arbiter: MEM-stage loads vs store-buffer drain.
// One outstanding cache transaction; response steered back to its owner.
// Loads win by default; a starvation counter and sb_full_i let stores through.
// Optional perf counters are built when DCACHE_ARB_PERF_EN is defined;
// otherwise the perf outputs read as zero and no counter flops exist.
module dcache_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  dcache_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST} state_t;

  state_t        state;
  logic          lock;
  logic          lock_st;
  logic [SW-1:0] starve_cnt;

  logic starved;
  logic sel_st;
  logic sel_vld;
  logic req_vld;
  logic accept;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // A stalled request keeps its side even if sb_full/valids move around.
  assign sel_st  = lock ? lock_st
                        : (bus.st_req_valid_i &&
                           (!bus.ld_req_valid_i || bus.sb_full_i || starved));
  assign sel_vld = sel_st ? bus.st_req_valid_i : bus.ld_req_valid_i;
  // Gated by rst_i so outputs read zero for the whole reset pulse.
  assign req_vld = !rst_i && (state == IDLE) && sel_vld;
  assign accept  = req_vld && bus.dc_req_ready_i;

  assign bus.dc_req_valid_o = req_vld;
  assign bus.dc_we_o        = req_vld && sel_st;
  assign bus.dc_addr_o      = !req_vld ? '0 : (sel_st ? bus.st_addr_i : bus.ld_addr_i);
  assign bus.dc_data_o      = (req_vld && sel_st) ? bus.st_data_i : '0;
  assign bus.ld_req_ready_o = accept && !sel_st;
  assign bus.st_req_ready_o = accept && sel_st;

  assign bus.ld_rsp_valid_o = (state == WAIT_LD) && bus.dc_rsp_valid_i;
  assign bus.ld_rsp_data_o  = bus.ld_rsp_valid_o ? bus.dc_rsp_data_i : '0;
  assign bus.st_rsp_valid_o = (state == WAIT_ST) && bus.dc_rsp_valid_i;
  assign bus.busy_o         = (state != IDLE);

  // Transaction FSM plus the selection lock held while the cache stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      lock    <= 1'b0;
      lock_st <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= sel_st ? WAIT_ST : WAIT_LD;
            lock  <= 1'b0;
          end else if (req_vld) begin
            lock    <= 1'b1;
            lock_st <= sel_st;
          end
        end
        WAIT_LD, WAIT_ST: begin
          if (bus.dc_rsp_valid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count load grants taken past a waiting store; a store grant clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (accept && sel_st) begin
      starve_cnt <= '0;
    end else if (accept && bus.st_req_valid_i && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_ld;
  logic [31:0] perf_st;
  logic [31:0] perf_cf;

  // Free-running wrapping grant and conflict counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ld <= '0;
      perf_st <= '0;
      perf_cf <= '0;
    end else begin
      if (accept && !sel_st) perf_ld <= perf_ld + 32'd1;
      if (accept && sel_st)  perf_st <= perf_st + 32'd1;
      if (state == IDLE && bus.ld_req_valid_i && bus.st_req_valid_i)
        perf_cf <= perf_cf + 32'd1;
    end
  end

  assign bus.perf_ld_grants_o = perf_ld;
  assign bus.perf_st_grants_o = perf_st;
  assign bus.perf_conflict_o  = perf_cf;
`else
  assign bus.perf_ld_grants_o = '0;
  assign bus.perf_st_grants_o = '0;
  assign bus.perf_conflict_o  = '0;
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: queue-driven requesters, a latency-model
// cache, a transaction-level reference model compared every cycle, and
// directed scenarios with literal expectations.
module tb_dcache_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [31:0] ld_q[$];
  logic [31:0] st_aq[$];
  logic [31:0] st_dq[$];
  int ld_pct = 100, st_pct = 100;
  int rdy_mode = 1;      // 0 random, 1 always, 2 never
  int sbf_mode = 2;      // 0 random, 1 forced high, 2 forced low
  int fixed_lat = 1;     // 0 -> random 1..3
  bit fix_data_en = 1'b0;
  logic [31:0] fix_data = 32'h0;
  bit spur_en = 1'b0;
  bit pend = 1'b0;
  int cnt = 0;

  // ---------------- reference model ----------------
  int m_own = 0;           // 0 none, 1 load, 2 store outstanding
  bit m_hold = 1'b0;       // a stalled pick is being held
  bit m_hold_st = 1'b0;
  int m_loads_past = 0;    // load grants taken while a store waited
  logic [31:0] m_pl = 0, m_ps = 0, m_pc = 0;

  bit e_req, e_pick_st, e_ldrdy, e_strdy, e_we, e_ldrsp, e_strsp, e_busy;
  logic [31:0] e_addr, e_data, e_ldata;

  // Expected outputs from the model, compared every cycle.
  always @(negedge clk) begin
    e_busy    = (m_own != 0);
    e_pick_st = m_hold ? m_hold_st
              : (bus.st_req_valid_i && (!bus.ld_req_valid_i || bus.sb_full_i || m_loads_past == SM));
    e_req     = !rst && !e_busy && (e_pick_st ? bus.st_req_valid_i : bus.ld_req_valid_i);
    e_we      = e_req && e_pick_st;
    e_addr    = !e_req ? 32'h0 : (e_pick_st ? bus.st_addr_i : bus.ld_addr_i);
    e_data    = e_we ? bus.st_data_i : 32'h0;
    e_ldrdy   = e_req && bus.dc_req_ready_i && !e_pick_st;
    e_strdy   = e_req && bus.dc_req_ready_i && e_pick_st;
    e_ldrsp   = (m_own == 1) && bus.dc_rsp_valid_i;
    e_strsp   = (m_own == 2) && bus.dc_rsp_valid_i;
    e_ldata   = e_ldrsp ? bus.dc_rsp_data_i : 32'h0;
    chk("dc_req_valid", 32'(bus.dc_req_valid_o), 32'(e_req));
    chk("dc_we", 32'(bus.dc_we_o), 32'(e_we));
    chk("dc_addr", bus.dc_addr_o, e_addr);
    chk("dc_data", bus.dc_data_o, e_data);
    chk("ld_req_ready", 32'(bus.ld_req_ready_o), 32'(e_ldrdy));
    chk("st_req_ready", 32'(bus.st_req_ready_o), 32'(e_strdy));
    chk("ld_rsp_valid", 32'(bus.ld_rsp_valid_o), 32'(e_ldrsp));
    chk("ld_rsp_data", bus.ld_rsp_data_o, e_ldata);
    chk("st_rsp_valid", 32'(bus.st_rsp_valid_o), 32'(e_strsp));
    chk("busy", 32'(bus.busy_o), 32'(e_busy));
`ifdef DCACHE_ARB_PERF_EN
    chk("perf_ld", bus.perf_ld_grants_o, m_pl);
    chk("perf_st", bus.perf_st_grants_o, m_ps);
    chk("perf_cf", bus.perf_conflict_o, m_pc);
`else
    chk("perf_ld_zero", bus.perf_ld_grants_o, 32'h0);
    chk("perf_st_zero", bus.perf_st_grants_o, 32'h0);
    chk("perf_cf_zero", bus.perf_conflict_o, 32'h0);
`endif
  end

  // Advance the model on each edge using the negedge decisions.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own <= 0; m_hold <= 1'b0; m_hold_st <= 1'b0; m_loads_past <= 0;
      m_pl <= 0; m_ps <= 0; m_pc <= 0;
    end else begin
      if (m_own == 0 && bus.ld_req_valid_i && bus.st_req_valid_i) m_pc <= m_pc + 1;
      if (e_req && bus.dc_req_ready_i) begin
        m_own  <= e_pick_st ? 2 : 1;
        m_hold <= 1'b0;
        if (e_pick_st) begin
          m_ps <= m_ps + 1;
          m_loads_past <= 0;
        end else begin
          m_pl <= m_pl + 1;
          if (bus.st_req_valid_i && m_loads_past < SM) m_loads_past <= m_loads_past + 1;
        end
      end else if (e_req) begin
        m_hold <= 1'b1;
        m_hold_st <= e_pick_st;
      end else if (m_own != 0 && bus.dc_rsp_valid_i) begin
        m_own <= 0;
      end
    end
  end

  // Grant log for the directed pattern checks.
  bit log_en = 1'b0;
  int glog[$];
  always @(negedge clk) begin
    if (log_en) begin
      if (bus.ld_req_ready_o) glog.push_back(0);
      if (bus.st_req_ready_o) glog.push_back(1);
    end
  end

  // Requesters and cache: hold valid/payload until ready, respond after latency.
  initial begin
    bit a_ld, a_st, a_acc;
    forever begin
      @(posedge clk);
      a_ld = e_ldrdy; a_st = e_strdy; a_acc = e_req && bus.dc_req_ready_i;
      #1;
      if (a_ld) begin
        if (ld_q.size() > 0) void'(ld_q.pop_front());
        bus.ld_req_valid_i = 1'b0; bus.ld_addr_i = '0;
      end
      if (!bus.ld_req_valid_i && ld_q.size() > 0 && $urandom_range(0, 99) < ld_pct) begin
        bus.ld_req_valid_i = 1'b1; bus.ld_addr_i = ld_q[0];
      end
      if (a_st) begin
        if (st_aq.size() > 0) begin void'(st_aq.pop_front()); void'(st_dq.pop_front()); end
        bus.st_req_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_data_i = '0;
      end
      if (!bus.st_req_valid_i && st_aq.size() > 0 && $urandom_range(0, 99) < st_pct) begin
        bus.st_req_valid_i = 1'b1; bus.st_addr_i = st_aq[0]; bus.st_data_i = st_dq[0];
      end
      case (sbf_mode)
        1:       bus.sb_full_i = 1'b1;
        2:       bus.sb_full_i = 1'b0;
        default: bus.sb_full_i = ($urandom_range(0, 9) == 0);
      endcase
      case (rdy_mode)
        1:       bus.dc_req_ready_i = 1'b1;
        2:       bus.dc_req_ready_i = 1'b0;
        default: bus.dc_req_ready_i = ($urandom_range(0, 9) < 6);
      endcase
      if (a_acc) begin
        pend = 1'b1;
        cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      end
      bus.dc_rsp_valid_i = 1'b0;
      bus.dc_rsp_data_i  = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.dc_rsp_valid_i = 1'b1;
          if (fix_data_en) bus.dc_rsp_data_i = fix_data;
          pend = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 19) == 0) begin
        bus.dc_rsp_valid_i = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    ld_q.delete(); st_aq.delete(); st_dq.delete();
    pend = 1'b0;
    bus.ld_req_valid_i = 1'b0; bus.ld_addr_i = '0;
    bus.st_req_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_data_i = '0;
    bus.dc_rsp_valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((ld_q.size() > 0 || st_aq.size() > 0 || bus.busy_o || pend) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'h1);
  endtask

  initial begin
    bus.ld_req_valid_i = 1'b0; bus.ld_addr_i = '0;
    bus.st_req_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_data_i = '0;
    bus.sb_full_i = 1'b0; bus.dc_req_ready_i = 1'b0;
    bus.dc_rsp_valid_i = 1'b0; bus.dc_rsp_data_i = '0;

    // Reset state
    @(negedge clk);
    chk("rst_dc_req_valid", 32'(bus.dc_req_valid_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    do_reset();

    // Single load, 2-cycle cache
    rdy_mode = 1; fixed_lat = 2; fix_data_en = 1'b1; fix_data = 32'hDEADBEEF;
    ld_q.push_back(32'h100);
    @(negedge clk);
    chk("t1_ld_ready_c0", 32'(bus.ld_req_ready_o), 32'h1);
    chk("t1_addr_c0", bus.dc_addr_o, 32'h100);
    chk("t1_data_c0", bus.dc_data_o, 32'h0);
    @(negedge clk);
    chk("t1_busy_c1", 32'(bus.busy_o), 32'h1);
    chk("t1_rsp_c1", 32'(bus.ld_rsp_valid_o), 32'h0);
    @(negedge clk);
    chk("t1_rsp_c2", 32'(bus.ld_rsp_valid_o), 32'h1);
    chk("t1_data_c2", bus.ld_rsp_data_o, 32'hDEADBEEF);
    chk("t1_busy_c2", 32'(bus.busy_o), 32'h1);
    @(negedge clk);
    chk("t1_busy_c3", 32'(bus.busy_o), 32'h0);
    fix_data_en = 1'b0;

    // Starvation pattern: 16 loads + 2 stores, both continuously valid
    do_reset();
    fixed_lat = 1; sbf_mode = 2;
    glog.delete(); log_en = 1'b1;
    for (int i = 0; i < 16; i++) ld_q.push_back(32'h1000 + 32'(i * 4));
    for (int i = 0; i < 2; i++) begin st_aq.push_back(32'h2000 + 32'(i * 4)); st_dq.push_back(32'hC0DE0000 + 32'(i)); end
    drain(300);
    log_en = 1'b0;
    chk("t2_grant_count", 32'(glog.size()), 32'd18);
    for (int i = 0; i < 18 && i < glog.size(); i++)
      chk($sformatf("t2_grant_%0d", i), 32'(glog[i]), (i == 8 || i == 17) ? 32'h1 : 32'h0);
`ifdef DCACHE_ARB_PERF_EN
    chk("t2_perf_ld", bus.perf_ld_grants_o, 32'd16);
    chk("t2_perf_st", bus.perf_st_grants_o, 32'd2);
`else
    chk("t2_perf_ld_off", bus.perf_ld_grants_o, 32'd0);
    chk("t2_perf_st_off", bus.perf_st_grants_o, 32'd0);
`endif

    // sb_full forces the store first
    do_reset();
    sbf_mode = 1;
    ld_q.push_back(32'h400);
    st_aq.push_back(32'h200); st_dq.push_back(32'h12345678);
    @(negedge clk);
    chk("t3_we", 32'(bus.dc_we_o), 32'h1);
    chk("t3_addr", bus.dc_addr_o, 32'h200);
    chk("t3_data", bus.dc_data_o, 32'h12345678);
    chk("t3_st_ready", 32'(bus.st_req_ready_o), 32'h1);
    chk("t3_ld_ready", 32'(bus.ld_req_ready_o), 32'h0);
    drain(50);

    // Lock: stalled load keeps the port while a full store buffer arrives
    do_reset();
    sbf_mode = 2; rdy_mode = 2; fixed_lat = 1;
    ld_q.push_back(32'h300);
    @(negedge clk);
    chk("t4_req_c0", 32'(bus.dc_req_valid_o), 32'h1);
    chk("t4_ld_ready_c0", 32'(bus.ld_req_ready_o), 32'h0);
    st_aq.push_back(32'h500); st_dq.push_back(32'h000000AA); sbf_mode = 1;
    @(negedge clk);
    chk("t4_addr_c1", bus.dc_addr_o, 32'h300);
    chk("t4_we_c1", 32'(bus.dc_we_o), 32'h0);
    @(negedge clk);
    chk("t4_addr_c2", bus.dc_addr_o, 32'h300);
    rdy_mode = 1;
    @(negedge clk);
    chk("t4_ld_ready_c3", 32'(bus.ld_req_ready_o), 32'h1);
    chk("t4_st_ready_c3", 32'(bus.st_req_ready_o), 32'h0);
    @(negedge clk);
    chk("t4_ld_rsp_c4", 32'(bus.ld_rsp_valid_o), 32'h1);
    @(negedge clk);
    chk("t4_st_ready_c5", 32'(bus.st_req_ready_o), 32'h1);
    chk("t4_addr_c5", bus.dc_addr_o, 32'h500);
    drain(50);

    // Reset mid WAIT_LD, late response afterwards is dropped
    do_reset();
    sbf_mode = 2; rdy_mode = 1; fixed_lat = 4;
    ld_q.push_back(32'h600);
    @(negedge clk);
    chk("t5_ld_ready_c0", 32'(bus.ld_req_ready_o), 32'h1);
    @(posedge clk); #3;
    chk("t5_busy_pre", 32'(bus.busy_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_busy_rst", 32'(bus.busy_o), 32'h0);
    chk("t5_req_rst", 32'(bus.dc_req_valid_o), 32'h0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_late_rsp_dropped", 32'(bus.ld_rsp_valid_o), 32'h0);
    chk("t5_idle", 32'(bus.busy_o), 32'h0);
    drain(50);

    // Randomized traffic against the model
    do_reset();
    rdy_mode = 0; sbf_mode = 0; fixed_lat = 0; spur_en = 1'b1;
    ld_pct = 70; st_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (ld_q.size() < 3 && $urandom_range(0, 1) == 1) ld_q.push_back($urandom);
      if (st_aq.size() < 3 && $urandom_range(0, 2) == 0) begin
        st_aq.push_back($urandom); st_dq.push_back($urandom);
      end
    end
    spur_en = 1'b0;
    drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
